button_event_arbiter: RTL
=========================

// Module: button_event_arbiter
// PURPOSE
//  Front end for the player push-buttons (HIT, STAY, NEW_GAME, ...). It syncs and
//  debounces each raw button, detects its press edge, and latches each press as a
//  pending event. A round-robin arbiter shares the single command channel into the
//  game FSM between all buttons, using a valid/ready handshake.
//  No press is lost or duplicated while the game FSM is busy.
// PARAMETERS
//  N_BTN       3       number of buttons / requesters (2..8)
//  DEB_CYCLES  500000  consecutive stable cycles before a level is accepted (10 ms @ 50 MHz)
//  CNT_W       $clog2(DEB_CYCLES+1)  debounce counter width (derived localparam)
//  ID_W        $clog2(N_BTN)         event id width (derived localparam)
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  btn_raw    in   N_BTN  raw button levels, asynchronous, 1 = pressed
//  enable     in   1      1 = accept new presses; 0 = drop presses, keep draining pending
//  evt_valid  out  1      event offered to the game FSM
//  evt_id     out  ID_W   index of the button whose press is offered
//  evt_ready  in   1      game FSM accepts the event (handshake when valid & ready)
//  pending    out  N_BTN  latched, not-yet-offered presses (status/debug)
//  overrun    out  1      1-cycle pulse: a press hit an already-pending bit (press merged)
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops 0, debounced levels 0, counters 0,
//   pending 0, evt_valid 0, evt_id 0, overrun 0, rr pointer = N_BTN-1 (index 0 first).
//  Per button:
//   - 2-flop synchronizer.
//   - Debounce: the counter clears whenever sync == deb_level. Otherwise it
//     increments. At count DEB_CYCLES-1, deb_level toggles and the counter clears.
//     Net effect: the level changes only after DEB_CYCLES consecutive differing cycles.
//   - press = deb_level & ~deb_level_q: a 1-cycle pulse on the rising edge only.
//     The release edge produces nothing.
//  Pending: on press & enable, pending[i] is set at the next edge.
//   - If pending[i] is already 1: overrun pulses and the press is merged
//     (no second event).
//   - When enable is 0, the press is dropped silently (no overrun).
//  Arbiter FSM, 2 states:
//   IDLE: if pending != 0, grant the first set bit searching upward from rr+1
//    (modulo N_BTN). Next cycle: evt_valid=1, evt_id=grant, pending[grant] cleared,
//    rr=grant -> OFFER.
//   OFFER: evt_valid/evt_id held stable until evt_ready=1 is sampled. Then
//    evt_valid=0 next cycle -> IDLE. No withdrawal without handshake.
//  Throughput: max 1 event per 2 cycles.
//  Latency: press pulse at cycle t -> pending at t+1 -> evt_valid at t+2 (from IDLE).
//  Simultaneous events:
//   - Press on the bit being granted that same cycle: the set wins. pending stays 1
//     and a second event follows; no overrun.
//   - Press on the button currently in OFFER: sets pending normally; no overrun.
//   - Multiple presses in the same cycle: all latched, offered in round-robin order.
//  evt_ready while evt_valid=0 is ignored.
//  Reset mid-OFFER: the event is discarded, evt_valid drops immediately (async).
//  A button held through reset release generates one event after DEB_CYCLES.
//  evt_id is 0 whenever in IDLE after reset; otherwise it holds its last value.
// STRUCTURE
//  Shared package (blackjack_pkg): button index constants BTN_HIT=0, BTN_STAY=1,
//   BTN_NEW=2; N_BTN_DEFAULT; arbiter state encoding ARB_IDLE/ARB_OFFER.
//  Sub-module btn_debounce_pe (clk, rst, raw, level, press): synchronizer +
//   debounce counter + rising-edge pulse; instantiated N_BTN times via generate.
//  Top level holds pending, overrun, the round-robin pointer and the arbiter FSM.
// TESTING (sim with DEB_CYCLES=4, N_BTN=3)
//  1 Glitch on btn_raw[0]: high 3 cycles, then low -> deb_level never rises;
//    no event, no overrun.
//  2 btn_raw[1] held high 10 cycles, evt_ready=1 -> exactly one event, evt_id=1,
//    evt_valid high 1 cycle, ~4+2 cycles after the synced rise.
//  3 Buttons 0,1,2 debounce in the same cycle, evt_ready=1 -> ids 0,1,2 in order,
//    2 cycles apart. Repeat with rr=0 -> order 1,2,0.
//  4 evt_ready=0 for 20 cycles, button 2 pressed twice -> evt_valid/evt_id=2 stable;
//    second press sets pending[2] (no overrun). Third press -> overrun=1 for 1 cycle.
//    After ready: two id=2 events total.
//  5 enable=0, press button 0 -> no pending, no overrun. Existing pending bits still
//    drain via handshake.
//  6 rst asserted mid-OFFER -> evt_valid, pending, overrun go 0 in the same cycle.
//    After release, the first grant goes to index 0.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared constants and types for the blackjack button front end.
// Button indices, default sizing and the arbiter state encoding.
package blackjack_pkg;

    localparam int BTN_HIT            = 0;
    localparam int BTN_STAY           = 1;
    localparam int BTN_NEW            = 2;
    localparam int N_BTN_DEFAULT      = 3;
    localparam int DEB_CYCLES_DEFAULT = 500000;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/btn_debounce_pe.sv
// One button: 2-flop synchronizer, debounce counter, rising-edge press pulse.
// Latency: 2 sync + DEB_CYCLES stable cycles to level; no backpressure (free-running).
module btn_debounce_pe #(
    parameter  int DEB_CYCLES = 500000,
    localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level_r;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Counter only runs while the synced input disagrees with the accepted level,
    // so any bounce back to the old level restarts the whole window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level_r <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_q <= level_r;
            if (sync_2 == level_r) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_r <= ~level_r;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = level_r;
    assign press = level_r & ~level_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button presses latched as pending events, round-robin offered on one channel.
// Latency: press pulse -> pending +1 -> evt_valid +2; evt_valid held until evt_ready, 1 event / 2 cycles max.
module button_event_arbiter
    import blackjack_pkg::*;
#(
    parameter  int N_BTN      = N_BTN_DEFAULT,
    parameter  int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    localparam int ID_W       = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] pending,
    output logic             overrun
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    logic             grant_fire;
    logic [ID_W-1:0]  evt_id_r;
    logic [N_BTN-1:0] pending_r;
    logic [N_BTN-1:0] pending_nxt;
    logic             overrun_r;
    logic             overrun_nxt;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] unused_deb_level;
    logic [N_BTN-1:0] set_req;
    logic [N_BTN-1:0] grant_oh;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_pe #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (unused_deb_level[i]),
            .press (press[i])
        );
    end

    // First pending bit strictly after the last grant, wrapping around.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!grant_vld && pending_r[(int'(rr) + k) % N_BTN]) begin
                grant_vld = 1'b1;
                grant     = ID_W'((int'(rr) + k) % N_BTN);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_vld) begin
                    grant_fire = 1'b1;
                    state_nxt  = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (evt_ready) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // A press landing on the bit being granted re-arms it rather than merging.
    always_comb begin
        set_req     = press & {N_BTN{enable}};
        grant_oh    = grant_fire ? (N_BTN'(1) << grant) : '0;
        pending_nxt = set_req | (pending_r & ~grant_oh);
        overrun_nxt = |(set_req & pending_r & ~grant_oh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= '0;
            overrun_r <= 1'b0;
            rr        <= ID_W'(N_BTN - 1);
            evt_id_r  <= '0;
        end else begin
            pending_r <= pending_nxt;
            overrun_r <= overrun_nxt;
            if (grant_fire) begin
                rr       <= grant;
                evt_id_r <= grant;
            end
        end
    end

    assign evt_valid = (state == ARB_OFFER);
    assign evt_id    = evt_id_r;
    assign pending   = pending_r;
    assign overrun   = overrun_r;

endmodule
